riscv_data_mem: RTL
===================

RISCV_DATA_MEM -- requirements
Module: riscv_data_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 262144; memory depth in 32-bit words, byte-addressable.
REQ-002 Parameter ADDR_W, default 18; word-index width; SHALL satisfy 2**ADDR_W >= DEPTH_WORDS.
REQ-003 Port clk  input  1  sole clock, all state updates on posedge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port req_valid  input  1  request present.
REQ-006 Port req_ready  output  1  request accepted when req_valid && req_ready at posedge.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_addr  input  32  byte address.
REQ-009 Port req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 Port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0 (LBU/LHU vs LB/LH).
REQ-011 Port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 Port rsp_valid  output  1  response present.
REQ-013 Port rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at posedge.
REQ-014 Port rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 Port rsp_err  output  1  access fault for the responded request.

Function
REQ-016 Two states: IDLE (rsp_valid=0), RESP (rsp_valid=1); accept in IDLE -> RESP; RESP with rsp_ready and no new accept -> IDLE; RESP with rsp_ready and new accept -> RESP.
REQ-017 req_ready SHALL equal !rst && (!rsp_valid || rsp_ready), combinationally; throughput one request per cycle.
REQ-018 Every accepted request (load or store) SHALL produce exactly one response, rsp_valid rising on the edge after acceptance (latency 1).
REQ-019 rsp_valid, rsp_rdata and rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-020 Word index = req_addr[ADDR_W+1:2]; lane = req_addr[1:0].
REQ-021 Store byte writes req_wdata[7:0] to lane; half writes req_wdata[15:0] to lanes {addr[1],0} and {addr[1],1}; word writes all four lanes; other lanes untouched.
REQ-022 Store writes the array at the acceptance edge; a load accepted on any later edge SHALL return the new data.
REQ-023 Load byte returns selected lane, half returns lanes per REQ-021, word returns full word; little-endian; extension per req_unsigned; word loads ignore req_unsigned.
REQ-024 Out of range (req_addr[31:2] >= DEPTH_WORDS) or req_size == 11 SHALL set rsp_err=1, rsp_rdata=0, and suppress any write.
REQ-025 Memory contents SHALL be retained across requests and SHALL NOT be initialised by hardware.

Reset
REQ-026 While rst=1 at a posedge: state -> IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0; memory array unchanged.
REQ-027 A pending response at reset SHALL be discarded; req_ready=0 during rst, so no request is accepted or written in a reset cycle.

Configuration
REQ-028 Macro RISCV_DMEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=00 SHALL set rsp_err=1, rsp_rdata=0, no write.
REQ-029 Macro undefined: misaligned half/word SHALL be force-aligned (clear addr[0] for half, addr[1:0] for word) and complete without error; range/size errors per REQ-024 unchanged.

Verification
REQ-030 Store word 0xDEADBEEF @0x100, then load word @0x100 -> rsp_rdata=0xDEADBEEF, rsp_err=0, each rsp_valid one cycle after accept.
REQ-031 After REQ-030, store byte 0x7F @0x102, load byte signed @0x103 -> 0xFFFFFFDE; load half unsigned @0x102 -> 0x0000DE7F; load word @0x100 -> 0xDE7FBEEF.
REQ-032 Back-to-back: 4 loads with rsp_ready=1 -> 4 responses on 4 consecutive cycles; rsp_ready=0 for 3 cycles -> req_ready=0, response held unchanged.
REQ-033 Load word @DEPTH_WORDS*4 and req_size=11 @0x0 -> rsp_err=1, rsp_rdata=0; store word @DEPTH_WORDS*4 -> rsp_err=1, word 0 unchanged.
REQ-034 Load half @0x101: with macro -> rsp_err=1; without macro -> data of half @0x100, rsp_err=0.
REQ-035 Assert rst while rsp_valid=1 -> next cycle rsp_valid=0, rsp_rdata=0; memory data written before reset still readable afterwards.

Source files
------------

// File: rtl/riscv_data_mem_if.sv
// Request/response bus between a RISC-V load/store unit (master) and its data memory (slave).
interface riscv_data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/riscv_data_mem.sv
// Byte-addressable RISC-V data memory, one request per cycle, one-cycle response latency.
// Optional macro RISCV_DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
module riscv_data_mem #(
    parameter int unsigned DEPTH_WORDS = 262144,
    parameter int unsigned ADDR_W      = 18
) (
    input logic             clk,
    input logic             rst,
    riscv_data_mem_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e state_q, state_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic              accept;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic              out_of_range;
    logic              bad_size;
    logic              misaligned;
    logic              req_err;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_lanes;

    logic [31:0] rd_word_q;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign bus.req_ready = !rst && (!bus.rsp_valid || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    assign word_idx      = bus.req_addr[ADDR_W+1:2];
    assign out_of_range  = {2'b00, bus.req_addr[31:2]} >= DEPTH_WORDS;
    assign bad_size      = bus.req_size == 2'b11;
    assign req_err       = out_of_range || bad_size || misaligned;

    // Lane selection: misaligned half/word either fault or get force-aligned.
    always_comb begin
        lane       = bus.req_addr[1:0];
        misaligned = 1'b0;
        byte_en    = 4'b0000;
        wdata_lanes = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                byte_en     = 4'b0001 << lane;
                wdata_lanes = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                lane        = {bus.req_addr[1], 1'b0};
`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
                misaligned  = bus.req_addr[0];
`endif
                byte_en     = 4'b0011 << lane;
                wdata_lanes = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                lane        = 2'b00;
`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
                misaligned  = |bus.req_addr[1:0];
`endif
                byte_en     = 4'b1111;
            end
            default: ;
        endcase
    end

    // Array has no reset so it can map onto block RAM and keep contents across rst.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_word_q <= '0;
            lane_q    <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
        end else if (accept) begin
            rd_word_q <= mem[word_idx];
            lane_q    <= lane;
            size_q    <= bus.req_size;
            uns_q     <= bus.req_unsigned;
            we_q      <= bus.req_we;
            err_q     <= req_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StResp;
            StResp: if (bus.rsp_ready) state_d = accept ? StResp : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shifted = rd_word_q >> {lane_q, 3'b000};
        case (size_q)
            2'b00:   load_data = {{24{shifted[7] & ~uns_q}}, shifted[7:0]};
            2'b01:   load_data = {{16{shifted[15] & ~uns_q}}, shifted[15:0]};
            default: load_data = rd_word_q;
        endcase
        bus.rsp_valid = state_q == StResp;
        bus.rsp_err   = bus.rsp_valid && err_q;
        bus.rsp_rdata = (bus.rsp_valid && !err_q && !we_q) ? load_data : 32'h0;
    end

endmodule
